// File: rtl/jtpang_pal_pkg.sv
// Shared types for the palette write front-end: RAM geometry, queue entry layout,
// commit FSM states and the CPU-address to palette-RAM-address swizzle.
package jtpang_pal_pkg;

  localparam int PAL_AW  = 12;
  localparam int PAL_DW  = 8;
  localparam int CPU_AW  = 11;
  localparam int ENTRY_W = 20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_WIN = 2'd1,
    COMMIT   = 2'd2
  } pal_st_t;

  typedef struct packed {
    logic              bank;
    logic [CPU_AW-1:0] addr;
    logic [PAL_DW-1:0] data;
  } pal_entry_t;

  // Byte half selects the upper RAM half so {G,B} and {0,R} live in separate 1K blocks
  function automatic logic [PAL_AW-1:0] pal_swizzle(input logic [CPU_AW-1:0] a,
                                                    input logic bank);
    return {a[0], bank, a[CPU_AW-1:1]};
  endfunction

endpackage

// File: rtl/jtpang_palwr_fifo.sv
// Synchronous FIFO, depth 2^AW, read data valid combinationally at the head.
// Latency: push visible one clk later; backpressure: push ignored when full unless popping.
module jtpang_palwr_fifo #(
  parameter int AW = 4,
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign pop_ok  = pop & ~empty;
  // A full queue still accepts a push in the cycle a slot is freed
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jtpang_palwr.sv
// Palette write front-end: queues CPU palette writes, commits them in blanking/video-off.
// Latency: strobe edge N -> ram_we N+3; stalls CPU (cpu_wait) when pending and queue full.
// JTPANG_PALWR_HBLANK_EN: also open the commit window during horizontal blank.
module jtpang_palwr
  import jtpang_pal_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pxl_cen,
  input  logic              LHBL,
  input  logic              LVBL,
  input  logic              video_en,
  input  logic              pal_bank,
  input  logic              pal_cs,
  input  logic              wr_n,
  input  logic [CPU_AW-1:0] cpu_addr,
  input  logic [PAL_DW-1:0] cpu_dout,
  output logic              cpu_wait,
  output logic [PAL_AW-1:0] ram_addr,
  output logic [PAL_DW-1:0] ram_din,
  output logic              ram_we,
  output logic              busy
);

  logic           strobe;
  logic           strobe_l;
  logic           stb_edge;
  logic           pend_vld;
  pal_entry_t     pend;
  pal_entry_t     head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FIFO_AW:0] fifo_level;
  logic           win_now;
  logic           win_r;
  logic           push;
  logic           pop;
  logic           last_pop;
  pal_st_t        st;
  logic           unused_ok;

  assign strobe   = pal_cs & ~wr_n;
  assign stb_edge = strobe & ~strobe_l;

`ifdef JTPANG_PALWR_HBLANK_EN
  assign win_now   = ~video_en | ~LVBL | ~LHBL;
  assign unused_ok = pxl_cen;
`else
  assign win_now   = ~video_en | ~LVBL;
  assign unused_ok = ^{pxl_cen, LHBL};
`endif

  assign pop      = win_r & ~fifo_empty;
  assign push     = pend_vld & (~fifo_full | pop);
  assign last_pop = pop & ~push & (fifo_level == (FIFO_AW+1)'(1));
  assign cpu_wait = pend_vld & fifo_full;
  assign busy     = pend_vld | ~fifo_empty;

  jtpang_palwr_fifo #(
    .AW (FIFO_AW),
    .DW (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (pend),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_l <= 1'b0;
      win_r    <= 1'b0;
      pend_vld <= 1'b0;
      pend     <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      st       <= IDLE;
    end else begin
      strobe_l <= strobe;
      win_r    <= win_now;

      // An edge arriving while the held entry cannot drain is dropped, never overwrites it
      if (stb_edge && (!pend_vld || push)) begin
        pend_vld  <= 1'b1;
        pend.bank <= pal_bank;
        pend.addr <= cpu_addr;
        pend.data <= cpu_dout;
      end else if (push) begin
        pend_vld <= 1'b0;
      end

      ram_we <= pop;
      if (pop) begin
        ram_addr <= pal_swizzle(head.addr, head.bank);
        ram_din  <= head.data;
      end

      case (st)
        IDLE: begin
          if (!fifo_empty)
            st <= !win_r ? WAIT_WIN : (last_pop ? IDLE : COMMIT);
        end
        WAIT_WIN: begin
          if (win_r) st <= last_pop ? IDLE : COMMIT;
        end
        COMMIT: begin
          if (last_pop || fifo_empty) st <= IDLE;
          else if (!win_r)            st <= WAIT_WIN;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtpang_palwr.sv
// Randomized bench for jtpang_palwr against a queue-based model of committed palette writes.
module tb_jtpang_palwr;

  logic        clk = 1'b0;
  logic        rst;
  logic        pxl_cen = 1'b0;
  logic        LHBL, LVBL, video_en, pal_bank, pal_cs, wr_n;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_wait, ram_we, busy;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  jtpang_palwr dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .video_en (video_en),
    .pal_bank (pal_bank),
    .pal_cs   (pal_cs),
    .wr_n     (wr_n),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_wait (cpu_wait),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) pxl_cen = ~pxl_cen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected RAM word: {ram_addr[11:0], data[7:0]} from the palette layout rules
  function automatic logic [19:0] model(input logic b, input logic [10:0] a, input logic [7:0] d);
    int ra;
    ra = ((int'(a) % 2) * 2048) + (int'(b) * 1024) + (int'(a) / 2);
    return {ra[11:0], d};
  endfunction

  always @(negedge clk) begin
    if (!rst && ram_we) begin
      pulses++;
      if (exp_q.size() == 0) chk("unexpected_we", ram_we, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("ram_addr", ram_addr, mon_e[19:8]);
        chk("ram_din", ram_din, mon_e[7:0]);
      end
    end
  end

  task automatic wr(input logic [10:0] a, input logic [7:0] d, input logic b);
    int n = 0;
    @(negedge clk);
    while (cpu_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (cpu_wait) chk("cpu_wait_timeout", cpu_wait, 0);
    pal_cs = 1'b1; wr_n = 1'b0; cpu_addr = a; cpu_dout = d; pal_bank = b;
    exp_q.push_back(model(b, a, d));
    @(posedge clk);
    @(negedge clk);
    pal_cs = 1'b0; wr_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic wr_rnd();
    wr(11'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int p0, p1, n;
    rst = 1'b1; LHBL = 1'b1; LVBL = 1'b1; video_en = 1'b1;
    pal_bank = 1'b0; pal_cs = 1'b0; wr_n = 1'b1; cpu_addr = '0; cpu_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_wait", cpu_wait, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;

    // Single write with palette free: exact N+3 timing and address swizzle
    video_en = 1'b0;
    settle();
    p0 = pulses;
    wr(11'h005, 8'hA3, 1'b1);
    #1 chk("t1_we_early", ram_we, 0);
    @(posedge clk);
    #1;
    chk("t1_we", ram_we, 1);
    chk("t1_addr", ram_addr, 12'hC02);
    chk("t1_din", ram_din, 8'hA3);
    chk("t1_busy", busy, 0);
    @(posedge clk);
    #1 chk("t1_we_once", ram_we, 0);
    drain("t1_drain", 20);
    chk("t1_pulses", pulses - p0, 1);

    // Active display holds writes until vertical blank
    @(negedge clk) video_en = 1'b1;
    settle();
    p0 = pulses;
    repeat (3) wr_rnd();
    repeat (10) @(negedge clk);
    chk("t2_no_we", pulses - p0, 0);
    chk("t2_busy", busy, 1);
    LVBL = 1'b0;
    drain("t2_drain", 50);
    chk("t2_pulses", pulses - p0, 3);
    chk("t2_busy_end", busy, 0);
    LVBL = 1'b1;

    // Long strobe yields one entry
    @(negedge clk) video_en = 1'b0;
    settle();
    p0 = pulses;
    @(negedge clk);
    pal_cs = 1'b1; wr_n = 1'b0; cpu_addr = 11'h3FF; cpu_dout = 8'h5C; pal_bank = 1'b0;
    exp_q.push_back(model(1'b0, 11'h3FF, 8'h5C));
    repeat (10) @(negedge clk);
    pal_cs = 1'b0; wr_n = 1'b1;
    drain("t3_drain", 30);
    chk("t3_pulses", pulses - p0, 1);

    // Overflow of a 16-deep queue stalls the CPU until a slot frees
    @(negedge clk) video_en = 1'b1;
    settle();
    p0 = pulses;
    for (int i = 0; i < 17; i++) wr_rnd();
    #1;
    chk("t4_cpu_wait", cpu_wait, 1);
    chk("t4_busy", busy, 1);
    @(negedge clk) video_en = 1'b0;
    n = 0;
    while (cpu_wait && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_wait_clear", cpu_wait, 0);
    drain("t4_drain", 100);
    chk("t4_pulses", pulses - p0, 17);

    // Window closes after three commits of a burst of eight
    @(negedge clk) video_en = 1'b1;
    settle();
    p0 = pulses;
    repeat (8) wr_rnd();
    settle();
    video_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) video_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_partial", pulses - p0, 3);
    chk("t5_busy", busy, 1);
    video_en = 1'b0;
    drain("t5_drain", 50);
    chk("t5_pulses", pulses - p0, 8);

    // Horizontal blank opens the window only with the option built in
    @(negedge clk) video_en = 1'b1;
    LHBL = 1'b0;
    settle();
    p0 = pulses;
    repeat (2) wr_rnd();
    repeat (20) @(negedge clk);
`ifdef JTPANG_PALWR_HBLANK_EN
    chk("t6_hblank_we", pulses - p0, 2);
    chk("t6_busy", busy, 0);
`else
    chk("t6_hblank_we", pulses - p0, 0);
    chk("t6_busy", busy, 1);
`endif
    LHBL = 1'b1;
    LVBL = 1'b0;
    drain("t6_drain", 50);
    LVBL = 1'b1;

    // Asynchronous reset in the middle of a commit burst
    settle();
    p0 = pulses;
    repeat (6) wr_rnd();
    @(negedge clk) video_en = 1'b0;
    n = 0;
    while (pulses - p0 < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t7_started", pulses - p0 >= 2, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t7_we", ram_we, 0);
    chk("t7_busy", busy, 0);
    chk("t7_cpu_wait", cpu_wait, 0);
    chk("t7_addr", ram_addr, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    p1 = pulses;
    repeat (15) @(negedge clk);
    chk("t7_no_we", pulses - p1, 0);
    chk("t7_busy_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
